// File: rtl/adder_axil_pkg.sv
// Shared definitions for the AXI4-Lite adder master: FSM states,
// adder register map offsets and response decoding.
package adder_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_A_RESP,
    WR_B,
    WR_B_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  localparam int REG_OPA_OFFSET = 'h00;
  localparam int REG_OPB_OFFSET = 'h04;
  localparam int REG_SUM_OFFSET = 'h08;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY) && resp[1];
  endfunction

endpackage

// File: rtl/adder_axil_master.sv
// AXI4-Lite master that runs one add per command: write operand A,
// write operand B, read the sum back, then present sum and error flag.
// Every output comes straight from a register; next values are computed
// in a single combinational block alongside the state transition.
module adder_axil_master
  import adder_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int OPA_OFFSET = REG_OPA_OFFSET,
  parameter int OPB_OFFSET = REG_OPB_OFFSET,
  parameter int SUM_OFFSET = REG_SUM_OFFSET
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  // command stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  // result stream
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_sum,
  output logic                    res_err,
  // write address channel
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  // write response channel
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Register addresses wrap modulo 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(BASE_ADDR + OPA_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(BASE_ADDR + OPB_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] SUM_ADDR = ADDR_WIDTH'(BASE_ADDR + SUM_OFFSET);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   b_reg, b_next;
  logic                    err_reg, err_next;
  logic [DATA_WIDTH-1:0]   sum_reg, sum_next;
  logic                    cmd_ready_reg, cmd_ready_next;
  logic                    res_valid_reg, res_valid_next;
  logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic                    awvalid_reg, awvalid_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    bready_reg, bready_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;

  // An address or data beat counts as done once its valid has dropped or
  // its handshake completes this cycle.
  logic aw_done;
  logic w_done;

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state_reg     <= IDLE;
      b_reg         <= '0;
      err_reg       <= 1'b0;
      sum_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      res_valid_reg <= 1'b0;
      awaddr_reg    <= '0;
      awvalid_reg   <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      araddr_reg    <= '0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      b_reg         <= b_next;
      err_reg       <= err_next;
      sum_reg       <= sum_next;
      cmd_ready_reg <= cmd_ready_next;
      res_valid_reg <= res_valid_next;
      awaddr_reg    <= awaddr_next;
      awvalid_reg   <= awvalid_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      araddr_reg    <= araddr_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
    end
  end

  // Next-state and next-output logic for the write A / write B / read sequence.
  always_comb begin
    state_next     = state_reg;
    b_next         = b_reg;
    err_next       = err_reg;
    sum_next       = sum_reg;
    res_valid_next = res_valid_reg;
    awaddr_next    = awaddr_reg;
    awvalid_next   = awvalid_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    araddr_next    = araddr_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    aw_done        = !awvalid_reg || m1_axi_awready;
    w_done         = !wvalid_reg || m1_axi_wready;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          b_next       = cmd_b;
          err_next     = 1'b0;
          awvalid_next = 1'b1;
          awaddr_next  = OPA_ADDR;
          wvalid_next  = 1'b1;
          wdata_next   = cmd_a;
          wstrb_next   = '1;
          state_next   = WR_A;
        end
      end

      WR_A, WR_B: begin
        // AW and W complete independently, in either order.
        if (awvalid_reg && m1_axi_awready) awvalid_next = 1'b0;
        if (wvalid_reg && m1_axi_wready)   wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          bready_next = 1'b1;
          state_next  = (state_reg == WR_A) ? WR_A_RESP : WR_B_RESP;
        end
      end

      WR_A_RESP: begin
        if (m1_axi_bvalid) begin
          err_next     = err_reg | resp_is_err(m1_axi_bresp);
          bready_next  = 1'b0;
          awvalid_next = 1'b1;
          awaddr_next  = OPB_ADDR;
          wvalid_next  = 1'b1;
          wdata_next   = b_reg;
          wstrb_next   = '1;
          state_next   = WR_B;
        end
      end

      WR_B_RESP: begin
        // A failed write still proceeds to the read.
        if (m1_axi_bvalid) begin
          err_next     = err_reg | resp_is_err(m1_axi_bresp);
          bready_next  = 1'b0;
          arvalid_next = 1'b1;
          araddr_next  = SUM_ADDR;
          state_next   = RD_ADDR;
        end
      end

      RD_ADDR: begin
        if (m1_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m1_axi_rvalid) begin
          sum_next       = m1_axi_rdata;
          err_next       = err_reg | resp_is_err(m1_axi_rresp);
          rready_next    = 1'b0;
          res_valid_next = 1'b1;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Ready for a command only once back in IDLE, so it stays low for the
    // whole accept-to-return window.
    cmd_ready_next = (state_next == IDLE);
  end

  assign cmd_ready      = cmd_ready_reg;
  assign res_valid      = res_valid_reg;
  assign res_sum        = sum_reg;
  assign res_err        = err_reg;
  assign m1_axi_awaddr  = awaddr_reg;
  assign m1_axi_awvalid = awvalid_reg;
  assign m1_axi_wdata   = wdata_reg;
  assign m1_axi_wstrb   = wstrb_reg;
  assign m1_axi_wvalid  = wvalid_reg;
  assign m1_axi_bready  = bready_reg;
  assign m1_axi_araddr  = araddr_reg;
  assign m1_axi_arvalid = arvalid_reg;
  assign m1_axi_rready  = rready_reg;

endmodule

// File: tb/tb_adder_axil_master.sv
// Bench for adder_axil_master: behavioural AXI4-Lite adder slave with
// configurable stalls and error responses, plus a result scoreboard.
`timescale 1ns/1ps
module tb_adder_axil_master;
  import adder_axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_sum;
  logic          res_err;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rvalid = 1'b0;
  logic          rready;

  always #5 clk = ~clk;

  adder_axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .m1_axi_aclk(clk), .m1_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_err(res_err),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave configuration
  int         aw_delay = 0;
  logic [1:0] bresp_a_cfg = RESP_OKAY;
  logic [1:0] bresp_b_cfg = RESP_OKAY;
  logic [1:0] rresp_cfg = RESP_OKAY;
  bit         r_stall = 1'b0;

  // handshake monitor (posedge, read-only on DUT/slave signals)
  int            cyc = 0;
  int            aw_fires = 0, w_fires = 0, b_fires = 0, ar_fires = 0, r_fires = 0;
  logic [AW-1:0] aw_fire_addr, ar_fire_addr;
  logic [DW-1:0] w_fire_data;
  logic [3:0]    w_fire_strb;
  int            accept_cyc = 0, res_hs_cyc = 0, n_accept = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (awvalid && awready) begin aw_fires++; aw_fire_addr = awaddr; end
      if (wvalid && wready) begin w_fires++; w_fire_data = wdata; w_fire_strb = wstrb; end
      if (bvalid && bready) b_fires++;
      if (arvalid && arready) begin ar_fires++; ar_fire_addr = araddr; end
      if (rvalid && rready) r_fires++;
      if (cmd_valid && cmd_ready) begin accept_cyc = cyc; n_accept++; end
      if (res_valid && res_ready) res_hs_cyc = cyc;
    end
  end

  // slave model (negedge)
  logic [DW-1:0] regs [4];
  int            aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
  bit            aw_got = 0, w_got = 0, r_pend = 0;
  logic [AW-1:0] aw_addr_l, aw_first_addr, last_ar_addr;
  logic [DW-1:0] w_data_l;
  int            aw_wait = 0, aw_len = 0, w_len = 0, last_aw_len = 0, last_w_len = 0;
  int            aw_addr_changed = 0, ar_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      aw_seen = aw_fires; w_seen = w_fires; b_seen = b_fires; ar_seen = ar_fires; r_seen = r_fires;
      aw_got = 0; w_got = 0; r_pend = 0; aw_wait = 0; aw_len = 0; w_len = 0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      for (int i = 0; i < 4; i++) regs[i] = '0;
    end else begin
      if (aw_fires != aw_seen) begin
        aw_seen = aw_fires; aw_got = 1; aw_addr_l = aw_fire_addr;
        aw_wait = 0; awready = (aw_delay == 0);
        last_aw_len = aw_len; aw_len = 0;
      end
      if (w_fires != w_seen) begin
        w_seen = w_fires; w_got = 1; w_data_l = w_fire_data;
        check("wstrb", 64'(w_fire_strb), 64'hF);
        last_w_len = w_len; w_len = 0;
      end
      if (b_fires != b_seen) begin b_seen = b_fires; bvalid = 1'b0; end
      if (aw_got && w_got && !bvalid) begin
        regs[aw_addr_l[3:2]] = w_data_l;
        regs[2] = regs[0] + regs[1];
        bresp = (aw_addr_l == 8'h04) ? bresp_b_cfg : bresp_a_cfg;
        bvalid = 1'b1; aw_got = 0; w_got = 0;
      end
      if (r_fires != r_seen) begin r_seen = r_fires; rvalid = 1'b0; end
      if (ar_fires != ar_seen) begin
        ar_seen = ar_fires; ar_count++; last_ar_addr = ar_fire_addr; r_pend = 1;
      end
      if (r_pend && !rvalid && !r_stall) begin
        rdata = regs[last_ar_addr[3:2]]; rresp = rresp_cfg; rvalid = 1'b1; r_pend = 0;
      end
      // channel-valid tracking for stall checks
      if (awvalid) begin
        if (aw_len == 0) aw_first_addr = awaddr;
        else if (awaddr !== aw_first_addr) aw_addr_changed++;
        aw_len++;
      end
      if (wvalid) w_len++;
      // ready generation
      wready = 1'b1;
      arready = 1'b1;
      if (aw_delay == 0) awready = 1'b1;
      else if (awvalid && !awready) begin
        aw_wait++;
        if (aw_wait >= aw_delay) awready = 1'b1;
      end
    end
  end

  // scoreboard: expected {err, sum} pushed at drive, popped at result handshake
  logic [DW:0] exp_q[$];
  int          n_done = 0, rise_cyc = 0;
  logic        res_valid_q = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !res_valid_q) rise_cyc = cyc;
      res_valid_q = res_valid;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_sum), 64'hDEAD);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          $display("result %0d: sum=0x%08h err=%0b (expected sum=0x%08h err=%0b)",
                   n_done, res_sum, res_err, e[DW-1:0], e[DW]);
          check("res_sum", 64'(res_sum), 64'(e[DW-1:0]));
          check("res_err", 64'(res_err), 64'(e[DW]));
        end
        n_done++;
      end
    end else begin
      res_valid_q = 1'b0;
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] exp_sum, input logic exp_err);
    int start;
    bit ok;
    start = n_accept;
    ok = 0;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    exp_q.push_back({exp_err, exp_sum});
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (n_accept != start) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_done >= target) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 64'(n_done), 64'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    int target;
    int ar_before;
    bit ok;
    logic [DW-1:0] hold_sum;
    target = 0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, res_valid}), 64'd0);
    check("rst_readies", 64'({bready, rready}), 64'd0);
    check("rst_res", 64'({res_err, res_sum}), 64'd0);
    check("rst_addr_data", 64'({awaddr, araddr, wdata, wstrb}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // zero-wait slave, 39 + 40
    res_ready = 1'b1;
    send(32'd39, 32'd40, 32'd79, 1'b0); target++;
    wait_done(target);
    check("latency", 64'(rise_cyc - accept_cyc), 64'd6);
    check("reg_opa", 64'(regs[0]), 64'd39);
    check("reg_opb", 64'(regs[1]), 64'd40);
    check("read_addr", 64'(last_ar_addr), 64'h08);

    // awready stalled 3 cycles, wready immediate
    aw_delay = 3;
    aw_addr_changed = 0;
    send(32'd100, 32'd23, 32'd123, 1'b0); target++;
    wait_done(target);
    aw_delay = 0;
    check("aw_valid_len", 64'(last_aw_len), 64'd3);
    check("w_valid_len", 64'(last_w_len), 64'd1);
    check("aw_addr_stable", 64'(aw_addr_changed), 64'd0);

    // SLVERR on operand B write: read still issued, error flagged
    bresp_b_cfg = 2'b10;
    ar_before = ar_count;
    send(32'd5, 32'd6, 32'd11, 1'b1); target++;
    wait_done(target);
    bresp_b_cfg = RESP_OKAY;
    check("read_after_berr", 64'(ar_count - ar_before), 64'd1);

    // DECERR on the read data
    rresp_cfg = 2'b11;
    send(32'd7, 32'd8, 32'd15, 1'b1); target++;
    wait_done(target);
    rresp_cfg = RESP_OKAY;

    // result held for 5 cycles with res_ready low
    res_ready = 1'b0;
    send(32'd1000, 32'd2000, 32'd3000, 1'b0); target++;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    if (!ok) check("res_valid_timeout", 64'd0, 64'd1);
    hold_sum = res_sum;
    check("hold_sum_value", 64'(hold_sum), 64'd3000);
    repeat (5) begin
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_sum", 64'(res_sum), 64'(hold_sum));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("hold_axi_idle", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done(target);

    // back-to-back commands, including wraparound
    res_ready = 1'b1;
    send(32'd10, 32'd20, 32'd30, 1'b0); target++;
    send(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); target++;
    check("b2b_accept_gap", 64'(accept_cyc - res_hs_cyc), 64'd1);
    wait_done(target);

    // reset while waiting in RD_DATA
    r_stall = 1'b1;
    send(32'd3, 32'd4, 32'd7, 1'b0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rready) begin ok = 1; break; end
    end
    if (!ok) check("rd_data_timeout", 64'd0, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valids", 64'({awvalid, wvalid, arvalid, res_valid}), 64'd0);
    check("arst_readies", 64'({bready, rready, cmd_ready}), 64'd0);
    exp_q.delete();
    r_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    send(32'd50, 32'd60, 32'd110, 1'b0); target++;
    wait_done(target);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
